// File: rtl/ks_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ks_nibble_serial_add_ctrl
//  Description : WIDTH-bit adder that walks the operands one nibble per cycle
//                through a single shared 4-bit Kogge-Stone slice. The
//                inter-nibble carry is kept in a register. Operands arrive on
//                a valid/ready handshake and the result leaves on a second
//                one.
//                Optional feature macro: KS_SERIAL_SUB_EN adds a 'sub' input
//                that selects a-b (two's complement) instead of a+b+cin.
//  Revision    : 1.0 - initial release
// ============================================================================
module ks_nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef KS_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    // Number of nibble steps; derived from WIDTH and not overridable.
    localparam int NIB     = WIDTH / 4;
    localparam int c_IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NIB - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Prefix carry operator cell: combines a high (g1,p1) span with the
    // adjacent lower (g0,p0) span. Returns {group generate, group propagate}.
    function automatic logic [1:0] carry_operator(
        input logic g1,
        input logic p1,
        input logic g0,
        input logic p0
    );
        carry_operator = {g1 | (p1 & g0), p1 & p0};
    endfunction

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_pbit;
    logic [4:0]         w_g;
    logic [4:0]         w_p;
    logic [4:0]         w_gn;
    logic [4:0]         w_pn;
    logic [3:0]         w_slice_sum;
    logic               w_slice_cout;
    logic               w_last;

    assign w_last = (r_idx == c_LAST_IDX);

    // Select the operand nibble addressed by the current step index.
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int i = 0; i < NIB; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_a_nib = r_a[i*4 +: 4];
                w_b_nib = r_b[i*4 +: 4];
            end
        end
    end

    // 4-bit Kogge-Stone slice. Position 0 of the prefix vectors holds the
    // carry-in as a pure generate; positions 1..4 hold operand bits 0..3.
    // After log2 levels, prefix position i is the carry into bit i and
    // position 4 is the slice carry-out.
    always_comb begin
        w_pbit = w_a_nib ^ w_b_nib;
        w_g    = {w_a_nib & w_b_nib, r_carry};
        w_p    = {w_pbit, 1'b0};
        w_gn   = w_g;
        w_pn   = w_p;
        for (int lv = 0; lv < 3; lv++) begin
            w_gn = w_g;
            w_pn = w_p;
            for (int k = 0; k < 5; k++) begin
                if (k >= (1 << lv)) begin
                    {w_gn[k], w_pn[k]} = carry_operator(w_g[k], w_p[k],
                                                        w_g[k - (1 << lv)],
                                                        w_p[k - (1 << lv)]);
                end
            end
            w_g = w_gn;
            w_p = w_pn;
        end
        w_slice_sum  = w_pbit ^ w_g[3:0];
        w_slice_cout = w_g[4];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: accept in IDLE, step NIB times, hold until consumed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (in_valid)  w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (w_last)    w_state_nxt = c_ST_DONE;
            c_ST_DONE: if (out_ready) w_state_nxt = c_ST_IDLE;
            default:                  w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            c_ST_IDLE: in_ready = 1'b1;
            c_ST_RUN:  busy     = 1'b1;
            c_ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture, per-nibble result write-back and carry chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_idx <= '0;
`ifdef KS_SERIAL_SUB_EN
                        // Subtract as a + ~b + 1; cin is not used here.
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
`else
                        r_b     <= b;
                        r_carry <= cin;
`endif
                    end
                end
                c_ST_RUN: begin
                    for (int i = 0; i < NIB; i++) begin
                        if (r_idx == c_IDX_W'(i)) begin
                            r_sum[i*4 +: 4] <= w_slice_sum;
                        end
                    end
                    r_carry <= w_slice_cout;
                    if (w_last) begin
                        r_cout <= w_slice_cout;
                        r_idx  <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_ks_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ks_nibble_serial_add_ctrl
//  Description : Self-checking bench for ks_nibble_serial_add_ctrl (WIDTH=16)
//                with directed scenarios and randomized operations checked
//                against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ks_nibble_serial_add_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;
`ifdef KS_SERIAL_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    ks_nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef KS_SERIAL_SUB_EN
        .sub       (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic, {cout, sum} modulo 2^(W+1).
    function automatic logic [W:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic s);
        if (SUB_EN && s) return {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE; returns when out_valid is seen (not consumed).
    // lat is the cycle number of first out_valid with the accept cycle as 0.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         output int lat, output logic [W-1:0] s_o, output logic c_o,
                         output int bad);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        cin       = ci;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        lat      = -1;
        bad      = 0;
        for (int t = 1; t <= 40; t++) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
            if (out_valid === 1'b1) begin
                lat = t;
                break;
            end
            tick();
        end
        s_o = sum;
        c_o = cout;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b busy=%b sum=%h cout=%b required 1 0 0 0000 0",
                     in_ready, out_valid, busy, sum, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic [W-1:0] esum, input logic ecout);
        int lat, bad;
        logic [W-1:0] s;
        logic c;
        op_sub = 1'b0;
        do_op(x, y, ci, lat, s, c, bad);
        n_checks++;
        if (s !== esum || c !== ecout) begin
            n_errors++;
            $display("FAIL %s_result: got sum=%h cout=%b required sum=%h cout=%b", name, s, c, esum, ecout);
        end
        n_checks++;
        if (lat !== NIB + 1) begin
            n_errors++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, NIB + 1);
        end
        n_checks++;
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL %s_busy_ready: got %0d bad cycles required 0", name, bad);
        end
        finish_op();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_return_idle: got in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     name, in_ready, out_valid, busy);
        end
    endtask

    task automatic test_hold();
        int lat, bad;
        logic [W-1:0] s;
        logic c;
        op_sub = 1'b0;
        do_op(16'h0000, 16'h0000, 1'b1, lat, s, c, bad);
        n_checks++;
        if (s !== 16'h0001 || c !== 1'b0 || lat !== NIB + 1) begin
            n_errors++;
            $display("FAIL hold_result: got sum=%h cout=%b lat=%0d required 0001 0 %0d", s, c, lat, NIB + 1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h0001 || cout !== 1'b0) begin
                n_errors++;
                $display("FAIL hold_stable: cycle %0d got out_valid=%b in_ready=%b sum=%h cout=%b required 1 0 0001 0",
                         i, out_valid, in_ready, sum, cout);
            end
        end
        finish_op();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] res [2];
        int acc [2];
        int n_acc = 0;
        int n_res = 0;
        logic acc_now;
        logic [W:0] e0, e1;
        op_sub    = 1'b0;
        e0        = ref_model(16'h000F, 16'h0001, 1'b0, 1'b0);
        e1        = ref_model(16'h00F0, 16'h0010, 1'b0, 1'b0);
        res[0]    = 'x;
        res[1]    = 'x;
        acc[0]    = 0;
        acc[1]    = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h000F;
        b         = 16'h0001;
        cin       = 1'b0;
        for (int c = 0; c < 60 && n_res < 2; c++) begin
            if (out_valid === 1'b1) begin
                res[n_res] = sum;
                n_res++;
            end
            acc_now = in_valid && (in_ready === 1'b1);
            if (acc_now && n_acc < 2) begin
                acc[n_acc] = c;
                n_acc++;
            end
            tick();
            if (acc_now && n_acc == 1) begin
                a = 16'h00F0;
                b = 16'h0010;
            end else if (acc_now) begin
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (n_res !== 2 || n_acc !== 2) begin
            n_errors++;
            $display("FAIL b2b_count: got results=%0d accepts=%0d required 2 2", n_res, n_acc);
        end
        n_checks++;
        if (res[0] !== e0[W-1:0] || res[1] !== e1[W-1:0]) begin
            n_errors++;
            $display("FAIL b2b_sums: got %h %h required %h %h", res[0], res[1], e0[W-1:0], e1[W-1:0]);
        end
        n_checks++;
        if (acc[1] - acc[0] !== NIB + 2) begin
            n_errors++;
            $display("FAIL b2b_spacing: got %0d required %0d", acc[1] - acc[0], NIB + 2);
        end
    endtask

    task automatic test_reset_abort();
        op_sub   = 1'b0;
        in_valid = 1'b1;
        a        = 16'h8000;
        b        = 16'h8000;
        cin      = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_immediate: got out_valid=%b in_ready=%b busy=%b sum=%h cout=%b required 0 1 0 0000 0",
                     out_valid, in_ready, busy, sum, cout);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_held: got out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_directed("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
    endtask

    task automatic test_sub();
        int lat, bad;
        logic [W-1:0] s;
        logic c;
        logic [W-1:0] xs [2] = '{16'h0005, 16'h0007};
        logic [W-1:0] ys [2] = '{16'h0007, 16'h0005};
        logic [W-1:0] es [2] = '{16'hFFFE, 16'h0002};
        logic         ec [2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            op_sub = 1'b1;
            do_op(xs[i], ys[i], 1'(i), lat, s, c, bad);
            n_checks++;
            if (s !== es[i] || c !== ec[i] || lat !== NIB + 1) begin
                n_errors++;
                $display("FAIL sub_%0d: got sum=%h cout=%b lat=%0d required %h %b %0d",
                         i, s, c, lat, es[i], ec[i], NIB + 1);
            end
            finish_op();
        end
        op_sub = 1'b0;
    endtask

    task automatic test_random();
        int lat, bad;
        logic [W-1:0] s, x, y;
        logic c, ci;
        logic [W:0] e;
        for (int i = 0; i < 30; i++) begin
            x      = W'($urandom);
            y      = W'($urandom);
            ci     = 1'($urandom);
            op_sub = SUB_EN ? 1'($urandom) : 1'b0;
            if (i == 0) begin
                x = 16'hFFFF;
                y = 16'hFFFF;
                ci = 1'b1;
                op_sub = 1'b0;
            end
            e = ref_model(x, y, ci, op_sub);
            do_op(x, y, ci, lat, s, c, bad);
            n_checks++;
            if ({c, s} !== e || lat !== NIB + 1 || bad !== 0) begin
                n_errors++;
                $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b got cout=%b sum=%h lat=%0d bad=%0d required cout=%b sum=%h lat=%0d",
                         i, x, y, ci, op_sub, c, s, lat, bad, e[W], e[W-1:0], NIB + 1);
            end
            finish_op();
        end
        op_sub = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        test_directed("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        test_hold();
        test_back_to_back();
        test_reset_abort();
        if (SUB_EN) test_sub();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
